// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single block port of ram_cache_glue between
// the I-cache (read-only) and the D-cache (read/write). One owner per block
// transfer, with one forced idle cycle between transfers so the glue's beat
// counter always restarts at 0.
module ram_port_arbiter #(
   parameter int unsigned BLOCKS     = 4,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic                    clock,
   input  logic                    reset,
   // I-cache side
   input  logic                    i_req,
   input  logic [31:0]             i_addr,
   output logic [BLOCKS-1:0][31:0] i_read_block,
   output logic                    i_miss,
   // D-cache side
   input  logic                    d_req,
   input  logic [31:0]             d_addr,
   input  logic                    d_we,
   input  logic [BLOCKS-1:0][31:0] d_write_block,
   output logic [BLOCKS-1:0][31:0] d_read_block,
   output logic                    d_miss,
   // glue side
   output logic                    mem_req,
   output logic [31:0]             mem_addr,
   output logic                    mem_we,
   output logic [BLOCKS-1:0][31:0] mem_write_block,
   input  logic [BLOCKS-1:0][31:0] mem_read_block,
   input  logic                    mem_miss,
   // debug
   output logic                    grant_d,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_I   = 2'd1,
      GNT_D   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   // last_served encoding: 0 = I-cache, 1 = D-cache
   localparam logic SERVED_I = 1'b0;
   localparam logic SERVED_D = 1'b1;

   state_t state, state_nxt;
   logic   last_served, last_served_nxt;
   state_t arb_pick;

   // State register and round-robin history
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_served <= SERVED_I;
      end else begin
         state       <= state_nxt;
         last_served <= last_served_nxt;
      end
   end

   // Arbitration choice, used whenever the port is free (IDLE or RELEASE)
   always_comb begin
      arb_pick = IDLE;
      if (i_req && d_req) begin
         if (FIXED_PRIO || (last_served == SERVED_I)) arb_pick = GNT_D;
         else                                         arb_pick = GNT_I;
      end else if (i_req) begin
         arb_pick = GNT_I;
      end else if (d_req) begin
         arb_pick = GNT_D;
      end
   end

   // Next state: hold grant until completion or abort, then one RELEASE cycle
   always_comb begin
      state_nxt       = state;
      last_served_nxt = last_served;
      unique case (state)
         IDLE, RELEASE: state_nxt = arb_pick;
         GNT_I: begin
            if (!i_req) begin
               state_nxt = RELEASE;
            end else if (!mem_miss) begin
               state_nxt       = RELEASE;
               last_served_nxt = SERVED_I;
            end
         end
         GNT_D: begin
            if (!d_req) begin
               state_nxt = RELEASE;
            end else if (!mem_miss) begin
               state_nxt       = RELEASE;
               last_served_nxt = SERVED_D;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: owner's request passed straight to the glue; only the owner sees data
   always_comb begin
      mem_req         = 1'b0;
      mem_addr        = 32'd0;
      mem_we          = 1'b0;
      mem_write_block = '0;
      i_miss          = 1'b1;
      d_miss          = 1'b1;
      i_read_block    = '0;
      d_read_block    = '0;
      busy            = (state != IDLE);
      grant_d         = (state == GNT_D);
      unique case (state)
         GNT_I: begin
            mem_req  = i_req;
            mem_addr = i_addr;
            i_miss   = !(i_req && !mem_miss);
            if (i_req) i_read_block = mem_read_block;
         end
         GNT_D: begin
            mem_req         = d_req;
            mem_addr        = d_addr;
            mem_we          = d_we;
            mem_write_block = d_write_block;
            d_miss          = !(d_req && !mem_miss);
            if (d_req && !d_we) d_read_block = mem_read_block;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. Two instances share the cache-side
// stimulus: u_rr (round-robin) and u_fp (D-cache fixed priority). Each has its
// own zero-latency glue model whose RAM returns the word address as data.
module tb_ram_port_arbiter;

   localparam int unsigned BLOCKS = 4;
   typedef logic [BLOCKS-1:0][31:0] blk_t;

   logic        clock;
   logic        reset;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr;
   blk_t        d_write_block;

   blk_t        i_rb [2];
   blk_t        d_rb [2];
   blk_t        m_wb [2];
   blk_t        m_rb [2];
   logic        m_req [2];
   logic        m_we [2];
   logic        m_miss [2];
   logic [31:0] m_addr [2];
   logic        i_miss [2];
   logic        d_miss [2];
   logic        grant_d [2];
   logic        busy [2];
   int unsigned beat [2];

   int n_pass  = 0;
   int n_total = 0;

   ram_port_arbiter #(.BLOCKS(BLOCKS), .FIXED_PRIO(1'b0)) u_rr (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_read_block(i_rb[0]), .i_miss(i_miss[0]),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_write_block(d_write_block),
      .d_read_block(d_rb[0]), .d_miss(d_miss[0]),
      .mem_req(m_req[0]), .mem_addr(m_addr[0]), .mem_we(m_we[0]),
      .mem_write_block(m_wb[0]), .mem_read_block(m_rb[0]), .mem_miss(m_miss[0]),
      .grant_d(grant_d[0]), .busy(busy[0])
   );

   ram_port_arbiter #(.BLOCKS(BLOCKS), .FIXED_PRIO(1'b1)) u_fp (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_read_block(i_rb[1]), .i_miss(i_miss[1]),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_write_block(d_write_block),
      .d_read_block(d_rb[1]), .d_miss(d_miss[1]),
      .mem_req(m_req[1]), .mem_addr(m_addr[1]), .mem_we(m_we[1]),
      .mem_write_block(m_wb[1]), .mem_read_block(m_rb[1]), .mem_miss(m_miss[1]),
      .grant_d(grant_d[1]), .busy(busy[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Glue model beat counter: restarts whenever mem_req drops or a block completes
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) beat[k] <= 0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_req[k] && m_miss[k]) beat[k] <= beat[k] + 1;
            else                       beat[k] <= 0;
         end
      end
   end

   // Glue model response: block ready on the last beat; data = word address
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         m_miss[k] = !(m_req[k] && (beat[k] == BLOCKS - 1));
         m_rb[k]   = '0;
         if (!m_miss[k])
            for (int b = 0; b < BLOCKS; b++) m_rb[k][b] = m_addr[k] + 32'(4 * b);
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      i_req         = 1'b0;
      d_req         = 1'b0;
      d_we          = 1'b0;
      i_addr        = 32'd0;
      d_addr        = 32'd0;
      d_write_block = '0;

      // Reset state
      #3;
      check("rst_mem_req", m_req[0], 1'b0);
      check("rst_i_miss", i_miss[0], 1'b1);
      check("rst_d_miss", d_miss[0], 1'b1);
      check("rst_busy", busy[0], 1'b0);
      check("rst_grant_d", grant_d[0], 1'b0);
      tick();
      reset = 1'b0;

      // Test 1: async reset in the middle of a D grant
      tick();                      // c0
      d_req  = 1'b1;
      d_addr = 32'h700;
      tick(); settle();            // c1
      check("t1_grant_d", grant_d[0], 1'b1);
      tick(); settle();            // c2
      check("t1_d_miss_mid", d_miss[0], 1'b1);
      #2 reset = 1'b1;
      #1;
      check("t1_async_mem_req", m_req[0], 1'b0);
      check("t1_async_d_miss", d_miss[0], 1'b1);
      check("t1_async_i_miss", i_miss[0], 1'b1);
      check("t1_async_grant_d", grant_d[0], 1'b0);
      d_req = 1'b0;
      tick();
      reset = 1'b0;
      settle();
      check("t1_busy", busy[0], 1'b0);
      check("t1_i_rb", i_rb[0], '0);
      check("t1_d_rb", d_rb[0], '0);

      // Test 2: lone I read of 0x100
      tick();                      // c0
      i_req  = 1'b1;
      i_addr = 32'h100;
      settle();
      check("t2_c0_mem_req", m_req[0], 1'b0);
      tick(); settle();            // c1
      check("t2_c1_mem_req", m_req[0], 1'b1);
      check("t2_c1_mem_addr", m_addr[0], 32'h100);
      check("t2_c1_mem_we", m_we[0], 1'b0);
      check("t2_c1_i_miss", i_miss[0], 1'b1);
      tick(); settle();            // c2
      check("t2_c2_i_miss", i_miss[0], 1'b1);
      tick(); settle();            // c3
      check("t2_c3_i_miss", i_miss[0], 1'b1);
      tick(); settle();            // c4
      check("t2_c4_i_miss", i_miss[0], 1'b0);
      check("t2_c4_i_rb", i_rb[0], 128'h0000010C_00000108_00000104_00000100);
      check("t2_c4_d_rb", d_rb[0], '0);
      tick();                      // c5
      i_req = 1'b0;
      settle();
      check("t2_c5_mem_req", m_req[0], 1'b0);
      check("t2_c5_busy", busy[0], 1'b1);
      tick(); settle();            // c6
      check("t2_c6_busy", busy[0], 1'b0);

      // Test 3: simultaneous I and D, round-robin after reset -> D first
      do_reset();
      tick();                      // c0
      i_req  = 1'b1;
      i_addr = 32'h400;
      d_req  = 1'b1;
      d_addr = 32'h300;
      d_we   = 1'b0;
      tick(); settle();            // c1
      check("t3_c1_grant_d", grant_d[0], 1'b1);
      check("t3_c1_mem_addr", m_addr[0], 32'h300);
      check("t3_c1_i_miss", i_miss[0], 1'b1);
      tick(); tick(); tick(); settle(); // c4
      check("t3_c4_d_miss", d_miss[0], 1'b0);
      check("t3_c4_d_rb", d_rb[0], 128'h0000030C_00000308_00000304_00000300);
      check("t3_c4_i_rb", i_rb[0], '0);
      tick();                      // c5
      d_req = 1'b0;
      settle();
      check("t3_c5_mem_req", m_req[0], 1'b0);
      check("t3_c5_busy", busy[0], 1'b1);
      tick(); settle();            // c6
      check("t3_c6_mem_req", m_req[0], 1'b1);
      check("t3_c6_mem_addr", m_addr[0], 32'h400);
      check("t3_c6_grant_d", grant_d[0], 1'b0);
      tick(); tick(); settle();    // c8
      check("t3_c8_i_miss", i_miss[0], 1'b1);
      tick(); settle();            // c9
      check("t3_c9_i_miss", i_miss[0], 1'b0);
      check("t3_c9_i_rb", i_rb[0], 128'h0000040C_00000408_00000404_00000400);
      tick();
      i_req = 1'b0;

      // Test 4: fixed priority, both requests held -> D re-granted every time
      do_reset();
      tick();                      // c0
      i_req  = 1'b1;
      i_addr = 32'h400;
      d_req  = 1'b1;
      d_addr = 32'h300;
      for (int c = 1; c <= 14; c++) begin
         tick(); settle();
         check("t4_i_miss", i_miss[1], 1'b1);
         check("t4_grant_d", grant_d[1], (c % 5) != 0);
         if ((c % 5) == 4) check("t4_d_done", d_miss[1], 1'b0);
      end
      tick();
      i_req = 1'b0;
      d_req = 1'b0;

      // Test 5: D write of {4,3,2,1} to 0x200
      do_reset();
      tick();                      // c0
      d_req         = 1'b1;
      d_addr        = 32'h200;
      d_we          = 1'b1;
      d_write_block = 128'h00000004_00000003_00000002_00000001;
      for (int c = 1; c <= 4; c++) begin
         tick(); settle();
         check("t5_mem_we", m_we[0], 1'b1);
         check("t5_mem_wb", m_wb[0], 128'h00000004_00000003_00000002_00000001);
         check("t5_mem_addr", m_addr[0], 32'h200);
         check("t5_d_rb", d_rb[0], '0);
         check("t5_d_miss", d_miss[0], c != 4);
      end
      tick();                      // c5
      d_req         = 1'b0;
      d_we          = 1'b0;
      d_write_block = '0;
      settle();
      check("t5_c5_mem_we", m_we[0], 1'b0);
      check("t5_c5_mem_req", m_req[0], 1'b0);

      // Test 6: I aborts at c2, pending D granted at c4 with a fresh beat count
      do_reset();
      tick();                      // c0
      i_req  = 1'b1;
      i_addr = 32'h500;
      tick(); settle();            // c1
      check("t6_c1_mem_req", m_req[0], 1'b1);
      tick();                      // c2
      i_req  = 1'b0;
      d_req  = 1'b1;
      d_addr = 32'h600;
      settle();
      check("t6_c2_i_miss", i_miss[0], 1'b1);
      check("t6_c2_mem_req", m_req[0], 1'b0);
      tick(); settle();            // c3
      check("t6_c3_mem_req", m_req[0], 1'b0);
      check("t6_c3_busy", busy[0], 1'b1);
      check("t6_c3_grant_d", grant_d[0], 1'b0);
      tick(); settle();            // c4
      check("t6_c4_grant_d", grant_d[0], 1'b1);
      check("t6_c4_mem_addr", m_addr[0], 32'h600);
      tick(); tick(); settle();    // c6
      check("t6_c6_d_miss", d_miss[0], 1'b1);
      tick(); settle();            // c7
      check("t6_c7_d_miss", d_miss[0], 1'b0);
      check("t6_c7_d_rb", d_rb[0], 128'h0000060C_00000608_00000604_00000600);
      tick();
      d_req = 1'b0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single block-level port of ram_cache_glue between the instruction cache (read-only) and the data cache (read/write).
- Grants one requester at a time and holds the grant for the whole multi-beat block transfer.
- Forces one idle cycle between transfers so the glue's beat counter restarts at 0.
- Sits between the two cache miss handlers and ram_cache_glue in the 1-stage core's memory subsystem.

Parameters:
- BLOCKS, 4, 32-bit words per cache block; must match ram_cache_glue.
- FIXED_PRIO, 0; 0 = round-robin between I and D; 1 = D-cache always wins ties.

Ports:
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  I-cache block read request
- i_addr  in  32  I-cache block address
- i_read_block  out  [BLOCKS-1:0][31:0]  block returned to the I-cache
- i_miss  out  1  high = I-cache transfer not complete
- d_req  in  1  D-cache block request
- d_addr  in  32  D-cache block address
- d_we  in  1  D-cache write (1) or read (0)
- d_write_block  in  [BLOCKS-1:0][31:0]  D-cache writeback data
- d_read_block  out  [BLOCKS-1:0][31:0]  block returned to the D-cache
- d_miss  out  1  high = D-cache transfer not complete
- mem_req  out  1  request to ram_cache_glue
- mem_addr  out  32  address to the glue
- mem_we  out  1  write enable to the glue
- mem_write_block  out  [BLOCKS-1:0][31:0]  write data to the glue
- mem_read_block  in  [BLOCKS-1:0][31:0]  read data from the glue
- mem_miss  in  1  glue miss / busy
- grant_d  out  1  debug: D-cache currently owns the port
- busy  out  1  debug: state is not IDLE

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D, RELEASE; state register plus a last_served flag (reset value = I).
- Reset (async, reset=1), any cycle including mid-transfer:
  - state=IDLE, last_served=I.
  - mem_req=0, mem_we=0, mem_addr=0, mem_write_block=0.
  - i_miss=1, d_miss=1, read blocks=0, grant_d=0, busy=0.
- Arbitration, evaluated on the clock edge in IDLE or RELEASE:
  - Only i_req -> GNT_I.
  - Only d_req -> GNT_D.
  - Both, FIXED_PRIO=1 -> GNT_D.
  - Both, FIXED_PRIO=0 -> the requester not equal to last_served.
  - Neither -> IDLE.
- Grant is registered: a request first seen in IDLE at edge N drives mem_req=1 from cycle N+1.
- In GNT_x, mem_req/mem_addr/mem_we/mem_write_block are combinational copies of requester x.
  - For the I-cache: mem_we=0, mem_write_block=0.
  - Outside GNT_I/GNT_D all mem_* outputs are 0.
- Requester miss, combinational:
  - x_miss = !(state==GNT_x && x_req && !mem_miss).
  - A non-granted requester always sees miss=1.
- Read data, combinational:
  - x_read_block = mem_read_block when state==GNT_x and x_req and !x_we; else 0.
  - Only the owner ever sees data.
- Completion: in GNT_x, a cycle with x_req=1 and mem_miss=0 completes the transfer.
  - Next state is RELEASE; last_served <= x.
- Abort: in GNT_x with x_req=0 -> RELEASE; last_served is not updated.
- RELEASE: forces mem_req=0 for exactly one cycle, which resets the glue's beat counter.
  - Arbitration is evaluated in the same cycle, so back-to-back transfers are separated by one idle cycle.
- Requester contract: hold addr, we and write_block stable from req assertion until its miss=0. Changes mid-grant are passed through unchecked.
- Latency with BLOCKS=4 and a zero-latency RAM:
  - req at cycle 0, mem_req at cycle 1, x_miss=0 at cycle 4 (BLOCKS cycles of grant).
  - A queued second requester gets mem_req at cycle 6.
- busy = (state != IDLE); grant_d = (state == GNT_D).

Test Plan:
1. Reset high mid-GNT_D -> mem_req=0, d_miss=i_miss=1 in the same cycle (async); after release, state IDLE and both read blocks 0.
2. Lone I read, i_addr=0x100, ram_memory_model, BLOCKS=4:
   - mem_req rises at cycle 1; i_miss=0 only at cycle 4.
   - i_read_block = {0x10C,0x108,0x104,0x100}; d_read_block stays 0.
   - mem_req=0 at cycle 5.
3. i_req and d_req rise together, FIXED_PRIO=0, after reset:
   - D granted first (last_served=I); d_miss=0 at cycle 4.
   - RELEASE at cycle 5; I granted at cycle 6; i_miss=0 at cycle 9.
4. Same stimulus with FIXED_PRIO=1 and d_req reasserted immediately after each completion -> D is re-granted every time; i_miss stays 1.
5. D write, d_addr=0x200, d_we=1, d_write_block={4,3,2,1}:
   - mem_we=1 and mem_write_block matches for all grant cycles.
   - d_read_block=0 throughout; d_miss=0 at cycle 4.
6. i_req dropped at cycle 2 mid-grant:
   - RELEASE at cycle 3, with mem_req=0 at cycle 3.
   - A pending d_req is granted at cycle 4, and its glue transfer starts at beat 0.
